// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Buffers signed 8-bit ALU commands, issues them one per edge to an
//   external ALU with a fixed pipeline latency, captures the ALU result LAT
//   edges after launch, and returns results in accept order through a
//   show-ahead result FIFO. Issue is credit-limited so that every launched
//   command is guaranteed a slot in the result FIFO.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready = FIFO not full)
//   cmd_sel, cmd_a, cmd_b      opcode and signed operands
//   cmd_tag                    caller tag, returned with the result
//   alu_sel, alu_a, alu_b      registered operands to the external ALU
//   alu_c, alu_z               ALU result and zero flag, sampled LAT edges
//                              after the operands were launched
//   res_valid / res_ready      result handshake (show-ahead head entry)
//   res_c, res_z, res_tag      head result, zero flag and tag
//   res_divz                   head command was a divide/modulo by zero
//   busy                       anything queued, in flight or unconsumed

module alu_issue_seq #(
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 4,
  parameter int LAT    = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_c,
  input  logic             alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_c,
  output logic             res_z,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_divz,
  output logic             busy
);

  localparam int CAW = $clog2(DEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int OW  = $clog2(RDEPTH + 1);

  localparam logic [CAW:0]  C_INC    = (CAW + 1)'(1);
  localparam logic [RAW:0]  R_INC    = (RAW + 1)'(1);
  localparam logic [OW-1:0] O_INC    = OW'(1);
  localparam logic [OW-1:0] O_MAX    = OW'(RDEPTH);
  localparam logic [2:0]    SEL_IDLE = 3'b111;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [2:0]       cq_sel [DEPTH];
  logic [7:0]       cq_a   [DEPTH];
  logic [7:0]       cq_b   [DEPTH];
  logic [TAG_W-1:0] cq_tag [DEPTH];

  logic [CAW:0] c_wp;
  logic [CAW:0] c_rp;
  logic         c_empty;
  logic         c_full;
  logic         ready_en;

  logic         accept;
  logic         issue;
  logic         push;
  logic         pop;

  assign c_empty   = (c_wp == c_rp);
  assign c_full    = (c_wp[CAW] != c_rp[CAW]) &&
                     (c_wp[CAW-1:0] == c_rp[CAW-1:0]);
  // ready_en holds cmd_ready low through reset and rises on the first edge.
  assign cmd_ready = ready_en & ~c_full;
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      cq_sel[c_wp[CAW-1:0]] <= cmd_sel;
      cq_a[c_wp[CAW-1:0]]   <= cmd_a;
      cq_b[c_wp[CAW-1:0]]   <= cmd_b;
      cq_tag[c_wp[CAW-1:0]] <= cmd_tag;
    end
  end

  logic [2:0]       h_sel;
  logic [7:0]       h_a;
  logic [7:0]       h_b;
  logic [TAG_W-1:0] h_tag;
  logic             h_divz;

  assign h_sel  = cq_sel[c_rp[CAW-1:0]];
  assign h_a    = cq_a[c_rp[CAW-1:0]];
  assign h_b    = cq_b[c_rp[CAW-1:0]];
  assign h_tag  = cq_tag[c_rp[CAW-1:0]];
  assign h_divz = ((h_sel == 3'd3) || (h_sel == 3'd4)) && (h_b == 8'd0);

  // ---------------------------------------------------------------------
  // Credit: outstanding = in-flight + result FIFO occupancy. It is a plain
  // register, so a pop only frees credit for the edge after the pop.
  // ---------------------------------------------------------------------
  logic [OW-1:0] outstanding;

  assign issue = ~c_empty & (outstanding < O_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en    <= 1'b0;
      c_wp        <= '0;
      c_rp        <= '0;
      outstanding <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) c_wp <= c_wp + C_INC;
      if (issue)  c_rp <= c_rp + C_INC;
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + O_INC;
        2'b01:   outstanding <= outstanding - O_INC;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Operand launch: head on issue, idle pattern otherwise
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_sel <= SEL_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (issue) begin
      alu_sel <= h_sel;
      alu_a   <= h_a;
      alu_b   <= h_b;
    end else begin
      alu_sel <= SEL_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Latency tracker: stage 0 loads on the issue edge, so the valid leaves
  // stage LAT-1 on the edge that samples the matching ALU output.
  // ---------------------------------------------------------------------
  logic [LAT-1:0]   sr_v;
  logic [LAT-1:0]   sr_divz;
  logic [TAG_W-1:0] sr_tag [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_v    <= '0;
      sr_divz <= '0;
      for (int i = 0; i < LAT; i++) sr_tag[i] <= '0;
    end else begin
      sr_v[0]    <= issue;
      sr_divz[0] <= issue & h_divz;
      sr_tag[0]  <= h_tag;
      for (int i = 1; i < LAT; i++) begin
        sr_v[i]    <= sr_v[i-1];
        sr_divz[i] <= sr_divz[i-1];
        sr_tag[i]  <= sr_tag[i-1];
      end
    end
  end

  assign push = sr_v[LAT-1];

  // ---------------------------------------------------------------------
  // Result FIFO (show-ahead). Storage is reset so the head reads zero
  // after reset. Credit guarantees push never meets a full FIFO.
  // ---------------------------------------------------------------------
  logic [7:0]       rq_c    [RDEPTH];
  logic             rq_z    [RDEPTH];
  logic [TAG_W-1:0] rq_tag  [RDEPTH];
  logic             rq_divz [RDEPTH];

  logic [RAW:0] r_wp;
  logic [RAW:0] r_rp;
  logic         r_empty;

  assign r_empty   = (r_wp == r_rp);
  assign res_valid = ~r_empty;
  assign pop       = res_valid & res_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < RDEPTH; i++) begin
        rq_c[i]    <= '0;
        rq_z[i]    <= 1'b0;
        rq_tag[i]  <= '0;
        rq_divz[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        rq_c[r_wp[RAW-1:0]]    <= alu_c;
        rq_z[r_wp[RAW-1:0]]    <= alu_z;
        rq_tag[r_wp[RAW-1:0]]  <= sr_tag[LAT-1];
        rq_divz[r_wp[RAW-1:0]] <= sr_divz[LAT-1];
        r_wp                   <= r_wp + R_INC;
      end
      if (pop) r_rp <= r_rp + R_INC;
    end
  end

  assign res_c    = rq_c[r_rp[RAW-1:0]];
  assign res_z    = rq_z[r_rp[RAW-1:0]];
  assign res_tag  = rq_tag[r_rp[RAW-1:0]];
  assign res_divz = rq_divz[r_rp[RAW-1:0]];

  assign busy = ~c_empty | (|sr_v) | ~r_empty;

endmodule
